keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 207 ++++++++++++++++++++
 tb/tb_keypad_scan.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with 2-flop column synchronizer and debounce.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key is held.
module keypad_scan #(
  parameter int ROW_CYCLES   = 100000,
  parameter int DEBOUNCE_N   = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int DW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam int MW = $clog2(DEBOUNCE_N + 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    col_meta_q, col_sync_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    row_q, row_d;
  logic [1:0]    col_lat_q, col_lat_d;
  logic [MW-1:0] match_q, match_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          pressed_q, pressed_d;
  logic          sample_s, any_low_s, lat_low_s, pulse_s;
  logic [1:0]    low_col_s;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_first_q, rpt_first_d;
`else
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_repeat_unused
  end
`endif

  assign row_out     = row_q;
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_pressed = pressed_q;

  always_comb begin
    sample_s  = (dwell_q == DW'(ROW_CYCLES - 1));
    any_low_s = (col_sync_q != 4'b1111);
    lat_low_s = ~col_sync_q[col_lat_q];
    if (!col_sync_q[0])      low_col_s = 2'd0;
    else if (!col_sync_q[1]) low_col_s = 2'd1;
    else if (!col_sync_q[2]) low_col_s = 2'd2;
    else                     low_col_s = 2'd3;
  end

  always_comb begin
    state_d   = state_q;
    dwell_d   = sample_s ? '0 : dwell_q + DW'(1);
    row_idx_d = row_idx_q;
    col_lat_d = col_lat_q;
    match_d   = match_q;
    code_d    = code_q;
    pressed_d = pressed_q;
    pulse_s   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
`endif
    case (state_q)
      ST_SCAN: begin
        if (sample_s && any_low_s) begin
          col_lat_d = low_col_s;
          match_d   = '0;
          state_d   = ST_DEBOUNCE;
        end else if (sample_s) begin
          row_idx_d = row_idx_q + 2'd1;
        end else begin
          row_idx_d = row_idx_q;
        end
      end
      ST_DEBOUNCE: begin
        if (sample_s && lat_low_s) begin
          if (match_q == MW'(DEBOUNCE_N - 1)) begin
            code_d    = {row_idx_q, col_lat_q};
            pulse_s   = 1'b1;
            pressed_d = 1'b1;
            match_d   = '0;
            state_d   = ST_HOLD;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
`endif
          end else begin
            match_d = match_q + MW'(1);
          end
        end else if (sample_s) begin
          match_d = '0;
          state_d = ST_SCAN;
        end else begin
          match_d = match_q;
        end
      end
      ST_HOLD: begin
        if (sample_s && !lat_low_s) begin
          // The sample that sees the key high is the first of the release run.
          if (DEBOUNCE_N <= 1) begin
            pressed_d = 1'b0;
            row_idx_d = 2'd0;
            match_d   = '0;
            state_d   = ST_SCAN;
          end else begin
            match_d = MW'(1);
            state_d = ST_RELEASE;
          end
        end else if (sample_s) begin
`ifdef KEYPAD_REPEAT_EN
          if (!rpt_first_q && (rpt_cnt_q >= RW'(REPEAT_DELAY - 1))) begin
            pulse_s     = 1'b1;
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
          end else if (rpt_first_q && (rpt_cnt_q >= RW'(REPEAT_RATE - 1))) begin
            pulse_s   = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RW'(1);
          end
`else
          match_d = '0;
`endif
        end else begin
          match_d = match_q;
        end
      end
      ST_RELEASE: begin
        if (sample_s && lat_low_s) begin
          match_d = '0;
          state_d = ST_HOLD;
        end else if (sample_s && (match_q >= MW'(DEBOUNCE_N - 1))) begin
          pressed_d = 1'b0;
          row_idx_d = 2'd0;
          match_d   = '0;
          state_d   = ST_SCAN;
        end else if (sample_s) begin
          match_d = match_q + MW'(1);
        end else begin
          match_d = match_q;
        end
      end
      default: begin
        state_d = ST_SCAN;
      end
    endcase
    valid_d = pulse_s & ~valid_q;
    row_d   = ~(4'b0001 << row_idx_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_meta_q <= 4'b0000;
      col_sync_q <= 4'b0000;
      state_q    <= ST_SCAN;
      dwell_q    <= '0;
      row_idx_q  <= 2'd0;
      row_q      <= 4'b1110;
      col_lat_q  <= 2'd0;
      match_q    <= '0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      pressed_q  <= 1'b0;
    end else begin
      col_meta_q <= col_in;
      col_sync_q <= col_meta_q;
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      row_idx_q  <= row_idx_d;
      row_q      <= row_d;
      col_lat_q  <= col_lat_d;
      match_q    <= match_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      pressed_q  <= pressed_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: keypad matrix model plus sample-indexed expectations for keypad_scan.
module tb_keypad_scan;
  localparam int RC = 4;
  localparam int DN = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  col_in, row_out, key_code;
  logic        key_valid, key_pressed;
  logic [15:0] keys;

  int   tests = 0;
  int   fails = 0;
  int   pulses = 0;
  logic prev_v = 1'b0;
  logic consec = 1'b0;

  keypad_scan #(.ROW_CYCLES(RC), .DEBOUNCE_N(DN), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .reset(reset), .col_in(col_in), .row_out(row_out),
    .key_code(key_code), .key_valid(key_valid), .key_pressed(key_pressed)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its column to a row that is being driven low.
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) pulses <= pulses + 1;
    if (key_valid === 1'b1 && prev_v === 1'b1) consec <= 1'b1;
    prev_v <= key_valid;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rowpat(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (i % 4));
  endfunction

  function automatic int lowest(input logic [3:0] m);
    for (int c = 0; c < 4; c++) if (m[c]) return c;
    return 0;
  endfunction

  function automatic bit exp_rep(input int hi);
`ifdef KEYPAD_REPEAT_EN
    return (hi >= RD) && (((hi - RD) % RR) == 0);
`else
    return (hi < 0);
`endif
  endfunction

  task automatic step();
    repeat (RC) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    keys = 16'h0000;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Press row r with column mask m; one-sample glitch h samples after acceptance, final release L samples later.
  task automatic run_press(input int r, input logic [3:0] m, input int h, input int l, input bit do_rst);
    int a, rel, d, code, p0, exp_p, hi, er;
    bit ev;
    if (do_rst) do_reset();
    p0    = pulses;
    exp_p = 0;
    code  = r * 4 + lowest(m);
    a     = r + DN;
    rel   = a + h + 2 + l;
    d     = rel + DN - 1;
    for (int n = 0; n <= d + 3; n++) begin
      keys = (n == a + h || n >= rel) ? 16'h0000 : (16'(m) << (4 * r));
      step();
      if (n > a && n < a + h) hi = n - a;
      else if (n > a + h + 1 && n < rel) hi = n - a - 2;
      else hi = -1;
      ev = (n == a) || (hi > 0 && exp_rep(hi));
      if (ev) exp_p++;
      if (n < r) er = (n + 1) % 4;
      else if (n < d) er = r;
      else er = (n - d) % 4;
      chk($sformatf("press k%0d n%0d valid", code, n), {3'b000, key_valid}, {3'b000, ev});
      chk($sformatf("press k%0d n%0d pressed", code, n), {3'b000, key_pressed}, {3'b000, (n >= a && n < d)});
      chk($sformatf("press k%0d n%0d row", code, n), row_out, rowpat(er));
      chk($sformatf("press k%0d n%0d code", code, n), key_code, (n >= a) ? 4'(code) : 4'd0);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    chk($sformatf("press k%0d pulse_total", code), 4'(pulses - p0), 4'(exp_p));
  endtask

  // Press row r, but the latched column reads high on debounce sample j, then stays released.
  task automatic run_bounce(input int r, input logic [3:0] m, input int j);
    int p0, er;
    do_reset();
    p0 = pulses;
    for (int n = 0; n <= r + j + 6; n++) begin
      keys = (n < r + j) ? (16'(m) << (4 * r)) : 16'h0000;
      step();
      if (n < r) er = (n + 1) % 4;
      else if (n <= r + j) er = r;
      else er = (n - j) % 4;
      chk($sformatf("bounce r%0d j%0d n%0d valid", r, j, n), {3'b000, key_valid}, 4'h0);
      chk($sformatf("bounce r%0d j%0d n%0d pressed", r, j, n), {3'b000, key_pressed}, 4'h0);
      chk($sformatf("bounce r%0d j%0d n%0d row", r, j, n), row_out, rowpat(er));
      chk($sformatf("bounce r%0d j%0d n%0d code", r, j, n), key_code, 4'd0);
    end
    chk($sformatf("bounce r%0d j%0d pulse_total", r, j), 4'(pulses - p0), 4'h0);
  endtask

  // Async reset while a key is in debounce or hold, then a full fresh press.
  task automatic run_mid_reset(input int r, input logic [3:0] m, input int s);
    do_reset();
    keys = 16'(m) << (4 * r);
    for (int n = 0; n <= r + s; n++) step();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk($sformatf("midreset s%0d row", s), row_out, 4'b1110);
    chk($sformatf("midreset s%0d valid", s), {3'b000, key_valid}, 4'h0);
    chk($sformatf("midreset s%0d pressed", s), {3'b000, key_pressed}, 4'h0);
    chk($sformatf("midreset s%0d code", s), key_code, 4'h0);
    keys = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_press(r, m, 2, 2, 1'b0);
  endtask

  initial begin
    keys  = 16'h0000;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("reset row", row_out, 4'b1110);
    chk("reset code", key_code, 4'h0);
    chk("reset valid", {3'b000, key_valid}, 4'h0);
    chk("reset pressed", {3'b000, key_pressed}, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle rotate c%0d", c), row_out, rowpat(c / RC));
    end

    run_press(2, 4'b0010, 10, 3, 1'b1);
    run_press(0, 4'b1010, 1, 2, 1'b1);
    run_bounce(2, 4'b0010, 2);
    for (int i = 0; i < 4; i++) begin
      run_press($urandom_range(0, 3), 4'($urandom_range(1, 15)),
                $urandom_range(1, 3), $urandom_range(2, 6), 1'b1);
      run_bounce($urandom_range(0, 3), 4'($urandom_range(1, 15)), $urandom_range(1, DN));
    end
    run_mid_reset(1, 4'b0100, 1);
    run_mid_reset(3, 4'b1001, DN + 2);

    chk("no back-to-back valid", {3'b000, consec}, 4'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
